// File: rtl/mpu_load_if.sv
// Bundle of the memory-side and register-file-side signals of the matrix
// load path. The load engine attaches through the slave modport; whatever
// drives memory and the register file (or a bench) attaches as master.
interface mpu_load_if #(
  parameter int MBITS           = 2,
  parameter int NBITS           = 2,
  parameter int MATRIX_REG_BITS = 2,
  parameter int FPBITS          = 31
);

  // Memory side: request, dimensions, target register and element stream
  logic                       load_req_in;
  logic [MBITS:0]             mem_m_load_size_in;
  logic [NBITS:0]             mem_n_load_size_in;
  logic [MATRIX_REG_BITS:0]   mem_load_addr_in;
  logic [FPBITS:0]            mem_load_element_in;
  logic                       mem_load_valid_in;
  logic                       mem_load_ready_out;

  // Register-file side: grant and write port
  logic                       load_ready_in;
  logic                       reg_load_en_out;
  logic [MATRIX_REG_BITS:0]   reg_load_addr_out;
  logic [MBITS:0]             reg_m_load_size_out;
  logic [NBITS:0]             reg_n_load_size_out;
  logic [MBITS:0]             reg_i_load_loc_out;
  logic [NBITS:0]             reg_j_load_loc_out;
  logic [FPBITS:0]            reg_load_element_out;

  // Status
  logic                       load_busy_out;
  logic                       load_done_out;

  modport slave (
    input  load_req_in,
    input  mem_m_load_size_in,
    input  mem_n_load_size_in,
    input  mem_load_addr_in,
    input  mem_load_element_in,
    input  mem_load_valid_in,
    output mem_load_ready_out,
    input  load_ready_in,
    output reg_load_en_out,
    output reg_load_addr_out,
    output reg_m_load_size_out,
    output reg_n_load_size_out,
    output reg_i_load_loc_out,
    output reg_j_load_loc_out,
    output reg_load_element_out,
    output load_busy_out,
    output load_done_out
  );

  modport master (
    output load_req_in,
    output mem_m_load_size_in,
    output mem_n_load_size_in,
    output mem_load_addr_in,
    output mem_load_element_in,
    output mem_load_valid_in,
    input  mem_load_ready_out,
    output load_ready_in,
    input  reg_load_en_out,
    input  reg_load_addr_out,
    input  reg_m_load_size_out,
    input  reg_n_load_size_out,
    input  reg_i_load_loc_out,
    input  reg_j_load_loc_out,
    input  reg_load_element_out,
    input  load_busy_out,
    input  load_done_out
  );

endinterface

// File: rtl/mpu_load.sv
// Matrix load engine: moves an MxN single-precision matrix from memory into
// the matrix register file, one element per accepted handshake, row-major.
// Each accepted element becomes exactly one registered write one cycle later,
// tagged with its (row, column) position.
module mpu_load #(
  parameter int MBITS           = 2,
  parameter int NBITS           = 2,
  parameter int MATRIX_REG_BITS = 2,
  parameter int FPBITS          = 31
) (
  input  logic      clk,
  input  logic      rst,
  mpu_load_if.slave load_if
);

  typedef enum logic [1:0] {
    LOAD_IDLE    = 2'd0,
    LOAD_REQUEST = 2'd1,
    LOAD_MATRIX  = 2'd2,
    LOAD_DONE    = 2'd3
  } load_state_t;

  localparam logic [MBITS:0]           M_ZERO    = {(MBITS+1){1'b0}};
  localparam logic [NBITS:0]           N_ZERO    = {(NBITS+1){1'b0}};
  localparam logic [MBITS:0]           M_ONE     = {{MBITS{1'b0}}, 1'b1};
  localparam logic [NBITS:0]           N_ONE     = {{NBITS{1'b0}}, 1'b1};
  localparam logic [MATRIX_REG_BITS:0] ADDR_ZERO = {(MATRIX_REG_BITS+1){1'b0}};
  localparam logic [FPBITS:0]          ELEM_ZERO = {(FPBITS+1){1'b0}};

  // FSM state
  load_state_t state_q, state_d;

  // Latched transfer descriptor (held until the next accepted request)
  logic [MBITS:0]           m_q, m_d;
  logic [NBITS:0]           n_q, n_d;
  logic [MATRIX_REG_BITS:0] addr_q, addr_d;

  // Position of the next element to be accepted
  logic [MBITS:0]           row_q, row_d;
  logic [NBITS:0]           col_q, col_d;

  // Registered write port toward the register file
  logic                     en_q, en_d;
  logic [MBITS:0]           i_q, i_d;
  logic [NBITS:0]           j_q, j_d;
  logic [FPBITS:0]          elem_q, elem_d;

  // Decoded handshake / status terms
  logic                     req_take_s;
  logic                     zero_size_s;
  logic                     accept_s;
  logic                     last_col_s;
  logic                     last_elem_s;
  logic                     mem_ready_s;
  logic                     busy_s;
  logic                     done_s;

  // A request only counts while idle; a zero dimension means nothing to move.
  assign req_take_s  = (state_q == LOAD_IDLE) && load_if.load_req_in;
  assign zero_size_s = (load_if.mem_m_load_size_in == M_ZERO) ||
                       (load_if.mem_n_load_size_in == N_ZERO);

  // mem_ready_s is only high in LOAD_MATRIX, so valid is ignored elsewhere.
  assign accept_s    = load_if.mem_load_valid_in && mem_ready_s;

  // In LOAD_MATRIX both dimensions are non-zero, so the subtractions never wrap.
  assign last_col_s  = (col_q == (n_q - N_ONE));
  assign last_elem_s = last_col_s && (row_q == (m_q - M_ONE));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_IDLE: begin
        if (req_take_s) begin
          if (zero_size_s) begin
            state_d = LOAD_DONE;
          end else begin
            state_d = LOAD_REQUEST;
          end
        end else begin
          state_d = LOAD_IDLE;
        end
      end
      LOAD_REQUEST: begin
        if (load_if.load_ready_in) begin
          state_d = LOAD_MATRIX;
        end else begin
          state_d = LOAD_REQUEST;
        end
      end
      LOAD_MATRIX: begin
        // The grant is not re-checked here: dropping it mid-transfer must not stall.
        if (accept_s && last_elem_s) begin
          state_d = LOAD_DONE;
        end else begin
          state_d = LOAD_MATRIX;
        end
      end
      LOAD_DONE: begin
        state_d = LOAD_IDLE;
      end
      default: begin
        state_d = LOAD_IDLE;
      end
    endcase
  end

  // FSM output decode: ready, busy and done follow the state directly
  always_comb begin
    mem_ready_s = 1'b0;
    busy_s      = 1'b1;
    done_s      = 1'b0;
    case (state_q)
      LOAD_IDLE: begin
        busy_s = 1'b0;
      end
      LOAD_REQUEST: begin
        busy_s = 1'b1;
      end
      LOAD_MATRIX: begin
        mem_ready_s = 1'b1;
      end
      LOAD_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Datapath next-state: descriptor latch, pointer walk and write staging
  always_comb begin
    m_d    = m_q;
    n_d    = n_q;
    addr_d = addr_q;
    row_d  = row_q;
    col_d  = col_q;
    en_d   = 1'b0;
    i_d    = i_q;
    j_d    = j_q;
    elem_d = elem_q;

    if (req_take_s) begin
      m_d    = load_if.mem_m_load_size_in;
      n_d    = load_if.mem_n_load_size_in;
      addr_d = load_if.mem_load_addr_in;
    end else begin
      m_d    = m_q;
      n_d    = n_q;
      addr_d = addr_q;
    end

    if (state_q == LOAD_IDLE) begin
      // Every transfer starts walking from element (0,0).
      row_d = M_ZERO;
      col_d = N_ZERO;
    end else if (accept_s) begin
      // Stage the write with the position the element was accepted at.
      en_d   = 1'b1;
      i_d    = row_q;
      j_d    = col_q;
      elem_d = load_if.mem_load_element_in;
      if (last_col_s) begin
        col_d = N_ZERO;
        row_d = row_q + M_ONE;
      end else begin
        col_d = col_q + N_ONE;
        row_d = row_q;
      end
    end else begin
      // No handshake: pointers hold and the write strobe stays low.
      row_d = row_q;
      col_d = col_q;
    end
  end

  // Datapath registers; reset clears every latch, pointer and output
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q    <= M_ZERO;
      n_q    <= N_ZERO;
      addr_q <= ADDR_ZERO;
      row_q  <= M_ZERO;
      col_q  <= N_ZERO;
      en_q   <= 1'b0;
      i_q    <= M_ZERO;
      j_q    <= N_ZERO;
      elem_q <= ELEM_ZERO;
    end else begin
      m_q    <= m_d;
      n_q    <= n_d;
      addr_q <= addr_d;
      row_q  <= row_d;
      col_q  <= col_d;
      en_q   <= en_d;
      i_q    <= i_d;
      j_q    <= j_d;
      elem_q <= elem_d;
    end
  end

  assign load_if.mem_load_ready_out   = mem_ready_s;
  assign load_if.load_busy_out        = busy_s;
  assign load_if.load_done_out        = done_s;
  assign load_if.reg_load_en_out      = en_q;
  assign load_if.reg_load_addr_out    = addr_q;
  assign load_if.reg_m_load_size_out  = m_q;
  assign load_if.reg_n_load_size_out  = n_q;
  assign load_if.reg_i_load_loc_out   = i_q;
  assign load_if.reg_j_load_loc_out   = j_q;
  assign load_if.reg_load_element_out = elem_q;

endmodule

// File: tb/tb_mpu_load.sv
// Bench for mpu_load: directed scenarios with literal expectations plus a
// long randomized phase, all checked every cycle against a transfer-level
// model (elements counted by k, position = k / N, k % N).
module tb_mpu_load;

  logic clk;
  logic rst;

  mpu_load_if #(.MBITS(2), .NBITS(2), .MATRIX_REG_BITS(2), .FPBITS(31)) bus ();

  mpu_load #(.MBITS(2), .NBITS(2), .MATRIX_REG_BITS(2), .FPBITS(31)) dut (
    .clk     (clk),
    .rst     (rst),
    .load_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 waiting for grant, 2 streaming, 3 done
  int          mphase  = 0;
  int          mk      = 0;
  int          mM      = 0;
  int          mN      = 0;
  int          mA      = 0;
  logic        exp_en  = 1'b0;
  int          exp_i   = 0;
  int          exp_j   = 0;
  logic [31:0] exp_el  = 32'd0;
  logic        started = 1'b0;

  // Transfer-level reference: count accepted elements and derive positions.
  always @(posedge clk) begin
    if (rst) begin
      mphase  <= 0;
      mk      <= 0;
      mM      <= 0;
      mN      <= 0;
      mA      <= 0;
      exp_en  <= 1'b0;
      exp_i   <= 0;
      exp_j   <= 0;
      exp_el  <= 32'd0;
      started <= 1'b1;
    end else begin
      exp_en <= 1'b0;
      case (mphase)
        0: if (bus.load_req_in) begin
          mM <= int'(bus.mem_m_load_size_in);
          mN <= int'(bus.mem_n_load_size_in);
          mA <= int'(bus.mem_load_addr_in);
          mk <= 0;
          mphase <= (bus.mem_m_load_size_in == 3'd0 || bus.mem_n_load_size_in == 3'd0) ? 3 : 1;
        end
        1: if (bus.load_ready_in) mphase <= 2;
        2: if (bus.mem_load_valid_in) begin
          exp_en <= 1'b1;
          exp_i  <= mk / mN;
          exp_j  <= mk % mN;
          exp_el <= bus.mem_load_element_in;
          mk     <= mk + 1;
          if (mk + 1 == mM * mN) mphase <= 3;
        end
        3: mphase <= 0;
        default: mphase <= 0;
      endcase
    end
  end

  // Write log of what the DUT actually wrote, for the literal checks.
  int          log_i[$];
  int          log_j[$];
  logic [31:0] log_e[$];

  // Single compare process: every output, every cycle, against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("en",    64'(bus.reg_load_en_out),      64'(exp_en));
      chk("busy",  64'(bus.load_busy_out),        64'(mphase != 0));
      chk("done",  64'(bus.load_done_out),        64'(mphase == 3));
      chk("ready", 64'(bus.mem_load_ready_out),   64'(mphase == 2));
      chk("m",     64'(bus.reg_m_load_size_out),  64'(mM));
      chk("n",     64'(bus.reg_n_load_size_out),  64'(mN));
      chk("addr",  64'(bus.reg_load_addr_out),    64'(mA));
      chk("i",     64'(bus.reg_i_load_loc_out),   64'(exp_i));
      chk("j",     64'(bus.reg_j_load_loc_out),   64'(exp_j));
      chk("elem",  64'(bus.reg_load_element_out), 64'(exp_el));
      if (bus.reg_load_en_out === 1'b1) begin
        log_i.push_back(int'(bus.reg_i_load_loc_out));
        log_j.push_back(int'(bus.reg_j_load_loc_out));
        log_e.push_back(bus.reg_load_element_out);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] ftab [0:8];

  task automatic clear_log();
    log_i.delete();
    log_j.delete();
    log_e.delete();
  endtask

  // One load: request, optional grant delay, stream with optional gaps,
  // optional noise requests, optional reset after 'abort' acceptances.
  // Returns at the negedge of the LOAD_DONE cycle (or after the reset cycle).
  task automatic do_load(input int m, input int n, input int a, input int gdelay,
                         input bit gap, input bit noise, input int abort, input bit use_tab);
    int k;
    int cyc;
    bit acc;
    @(negedge clk);
    bus.load_req_in        = 1'b1;
    bus.mem_m_load_size_in = 3'(m);
    bus.mem_n_load_size_in = 3'(n);
    bus.mem_load_addr_in   = 3'(a);
    bus.mem_load_valid_in  = 1'b0;
    bus.load_ready_in      = 1'b0;
    @(negedge clk);
    bus.load_req_in = 1'b0;
    if (m == 0 || n == 0) begin
      #1;
      chk("zero_done",  64'(bus.load_done_out),      64'd1);
      chk("zero_en",    64'(bus.reg_load_en_out),    64'd0);
      chk("zero_ready", 64'(bus.mem_load_ready_out), 64'd0);
      return;
    end
    for (int d = 0; d < gdelay; d++) begin
      #1;
      chk("wait_ready", 64'(bus.mem_load_ready_out), 64'd0);
      chk("wait_en",    64'(bus.reg_load_en_out),    64'd0);
      bus.mem_load_valid_in = 1'b1;
      @(negedge clk);
    end
    bus.load_ready_in = 1'b1;
    @(negedge clk);
    bus.load_ready_in = 1'b0;
    k = 0;
    cyc = 0;
    while (k < m * n && cyc < 200) begin
      if (abort >= 0 && k == abort) begin
        rst = 1'b1;
        bus.mem_load_valid_in = 1'b0;
        bus.load_req_in = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_en",   64'(bus.reg_load_en_out),     64'd0);
        chk("rst_busy", 64'(bus.load_busy_out),       64'd0);
        chk("rst_m",    64'(bus.reg_m_load_size_out), 64'd0);
        chk("rst_elem", 64'(bus.reg_load_element_out), 64'd0);
        rst = 1'b0;
        return;
      end
      bus.mem_load_valid_in   = gap ? ((cyc % 2) == 0) : 1'b1;
      bus.mem_load_element_in = (use_tab && k < 9) ? ftab[k] : $urandom;
      if (noise) begin
        bus.load_req_in        = 1'b1;
        bus.mem_m_load_size_in = 3'd7;
        bus.mem_n_load_size_in = 3'd7;
        bus.mem_load_addr_in   = 3'd6;
      end else begin
        bus.load_req_in = 1'b0;
      end
      acc = bus.mem_load_valid_in && bus.mem_load_ready_out;
      @(negedge clk);
      cyc++;
      if (acc) k++;
    end
    bus.mem_load_valid_in = 1'b0;
    bus.load_req_in = 1'b0;
    if (k < m * n) begin
      n_err++;
      $display("FAIL timeout: accepted %0d of %0d elements", k, m * n);
    end
    #1;
    chk("done_pulse", 64'(bus.load_done_out),      64'd1);
    chk("done_write", 64'(bus.reg_load_en_out),    64'd1);
    chk("done_i",     64'(bus.reg_i_load_loc_out), 64'(m - 1));
    chk("done_j",     64'(bus.reg_j_load_loc_out), 64'(n - 1));
  endtask

  initial begin
    ftab[0] = 32'h3f80_0000; ftab[1] = 32'h4000_0000; ftab[2] = 32'h4040_0000;
    ftab[3] = 32'h4080_0000; ftab[4] = 32'h40a0_0000; ftab[5] = 32'h40c0_0000;
    ftab[6] = 32'h40e0_0000; ftab[7] = 32'h4100_0000; ftab[8] = 32'h4110_0000;

    rst = 1'b1;
    bus.load_req_in = 1'b0;
    bus.mem_m_load_size_in = 3'd0;
    bus.mem_n_load_size_in = 3'd0;
    bus.mem_load_addr_in = 3'd0;
    bus.mem_load_element_in = 32'd0;
    bus.mem_load_valid_in = 1'b0;
    bus.load_ready_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_en",   64'(bus.reg_load_en_out),      64'd0);
    chk("reset_busy", 64'(bus.load_busy_out),        64'd0);
    chk("reset_done", 64'(bus.load_done_out),        64'd0);
    chk("reset_addr", 64'(bus.reg_load_addr_out),    64'd0);
    chk("reset_rdy",  64'(bus.mem_load_ready_out),   64'd0);
    rst = 1'b0;

    // 2x3 into register 1, elements 1.0..6.0, literal write sequence
    clear_log();
    do_load(2, 3, 1, 0, 1'b0, 1'b0, -1, 1'b1);
    @(negedge clk);
    #1;
    chk("after_done_busy", 64'(bus.load_busy_out), 64'd0);
    chk("w2x3_count", 64'(log_i.size()), 64'd6);
    if (log_i.size() == 6) begin
      chk("w2x3_i0", 64'(log_i[0]), 64'd0); chk("w2x3_j0", 64'(log_j[0]), 64'd0);
      chk("w2x3_i2", 64'(log_i[2]), 64'd0); chk("w2x3_j2", 64'(log_j[2]), 64'd2);
      chk("w2x3_i3", 64'(log_i[3]), 64'd1); chk("w2x3_j3", 64'(log_j[3]), 64'd0);
      chk("w2x3_i5", 64'(log_i[5]), 64'd1); chk("w2x3_j5", 64'(log_j[5]), 64'd2);
      chk("w2x3_e0", 64'(log_e[0]), 64'h3f80_0000);
      chk("w2x3_e4", 64'(log_e[4]), 64'h40a0_0000);
      chk("w2x3_e5", 64'(log_e[5]), 64'h40c0_0000);
    end
    chk("w2x3_addr", 64'(bus.reg_load_addr_out), 64'd1);

    // 3x3 with gaps, row-major order
    clear_log();
    do_load(3, 3, 2, 0, 1'b1, 1'b0, -1, 1'b1);
    @(negedge clk);
    #1;
    chk("w3x3_count", 64'(log_i.size()), 64'd9);
    if (log_i.size() == 9) begin
      chk("w3x3_i7", 64'(log_i[7]), 64'd2); chk("w3x3_j7", 64'(log_j[7]), 64'd1);
      chk("w3x3_e8", 64'(log_e[8]), 64'h4110_0000);
    end

    // grant withheld for 5 cycles
    do_load(2, 2, 3, 5, 1'b0, 1'b0, -1, 1'b0);

    // zero-size request
    clear_log();
    do_load(0, 4, 5, 0, 1'b0, 1'b0, -1, 1'b0);
    @(negedge clk);
    #1;
    chk("zero_writes", 64'(log_i.size()), 64'd0);
    chk("zero_n_latched", 64'(bus.reg_n_load_size_out), 64'd4);

    // reset after 3 of 6, then a fresh 1x1
    do_load(2, 3, 4, 0, 1'b0, 1'b0, 3, 1'b1);
    clear_log();
    do_load(1, 1, 2, 0, 1'b0, 1'b0, -1, 1'b1);
    @(negedge clk);
    #1;
    chk("w1x1_count", 64'(log_i.size()), 64'd1);
    if (log_i.size() == 1) begin
      chk("w1x1_i", 64'(log_i[0]), 64'd0);
      chk("w1x1_j", 64'(log_j[0]), 64'd0);
    end

    // 2x2 with conflicting requests during transfer, then back-to-back load
    do_load(2, 2, 1, 0, 1'b0, 1'b1, -1, 1'b0);
    chk("noise_m", 64'(bus.reg_m_load_size_out), 64'd2);
    chk("noise_n", 64'(bus.reg_n_load_size_out), 64'd2);
    do_load(1, 2, 7, 0, 1'b0, 1'b0, -1, 1'b0);
    chk("b2b_addr", 64'(bus.reg_load_addr_out), 64'd7);

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst                     = ($urandom_range(0, 299) == 0);
      bus.load_req_in         = ($urandom_range(0, 3) == 0);
      bus.mem_m_load_size_in  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 3));
      bus.mem_n_load_size_in  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 3));
      bus.mem_load_addr_in    = 3'($urandom_range(0, 7));
      bus.mem_load_element_in = $urandom;
      bus.mem_load_valid_in   = ($urandom_range(0, 2) != 0);
      bus.load_ready_in       = ($urandom_range(0, 1) == 1);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
